// File: rtl/song_defs_pkg.sv
// Shared note player definitions: widths, player state encoding and the
// equal-tempered phase-step reference used to build the frequency ROM.
package song_defs_pkg;

   localparam int NOTE_WIDTH      = 6;
   localparam int DURATION_WIDTH  = 6;
   localparam int NUM_NOTES       = 1 << NOTE_WIDTH;
   localparam int REF_PHASE_WIDTH = 22;
   localparam int TOP_OCTAVE      = 5;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      LOAD    = 2'b01,
      PLAYING = 2'b10,
      DONE    = 2'b11
   } player_state_t;

   // Steps for the top octave (A6..G#7) at 48 kHz with a 22-bit phase;
   // lower octaves are exact right shifts of these.
   function automatic int unsigned top_octave_step(input int semitone);
      case (semitone)
         0:       return 32'd153791;
         1:       return 32'd162936;
         2:       return 32'd172624;
         3:       return 32'd182889;
         4:       return 32'd193764;
         5:       return 32'd205286;
         6:       return 32'd217493;
         7:       return 32'd230426;
         8:       return 32'd244128;
         9:       return 32'd258644;
         10:      return 32'd274024;
         default: return 32'd290318;
      endcase
   endfunction

   // Note 0 is a rest; note n>0 sits in octave (n-1)/12, semitone (n-1)%12.
   function automatic int unsigned note_step_ref(input int note);
      if (note <= 0)
         return 32'd0;
      return top_octave_step((note - 1) % 12) >> (TOP_OCTAVE - (note - 1) / 12);
   endfunction

endpackage

// File: rtl/frequency_rom.sv
// Note index to phase-step lookup, 64 entries, one-cycle registered read.
// Entry 0 (rest) is zero so a rest never advances the phase.
module frequency_rom
   import song_defs_pkg::*;
#(
   parameter int PHASE_WIDTH = 22
)(
   input  logic                   clk,
   input  logic [NOTE_WIDTH-1:0]  addr,
   output logic [PHASE_WIDTH-1:0] data
);

   logic [PHASE_WIDTH-1:0] rom_mem [NUM_NOTES];
   logic [PHASE_WIDTH-1:0] data_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_NOTES; gi++) begin : g_rom
         localparam logic [63:0] REF_STEP = 64'(note_step_ref(gi));
         // Rescale the 22-bit reference steps to the configured phase width.
         if (PHASE_WIDTH >= REF_PHASE_WIDTH) begin : g_up
            assign rom_mem[gi] = PHASE_WIDTH'(REF_STEP << (PHASE_WIDTH - REF_PHASE_WIDTH));
         end else begin : g_dn
            assign rom_mem[gi] = PHASE_WIDTH'(REF_STEP >> (REF_PHASE_WIDTH - PHASE_WIDTH));
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      data_reg <= rom_mem[addr];
   end

   assign data = data_reg;

endmodule

// File: rtl/note_player.sv
// One voice: latches a note, counts its duration in beats and advances a
// phase accumulator on each sample request for the downstream wave ROMs.
module note_player
   import song_defs_pkg::*;
#(
   parameter int PHASE_WIDTH = 22,
   parameter int ADDR_WIDTH  = 10
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      play,
   input  logic                      new_note,
   input  logic [NOTE_WIDTH-1:0]     note,
   input  logic [DURATION_WIDTH-1:0] duration,
   input  logic                      beat,
   input  logic                      generate_next_sample,
   output logic                      note_done,
   output logic [ADDR_WIDTH-1:0]     sample_addr,
   output logic                      sample_valid,
   output logic                      is_rest
);

   player_state_t             state_reg, state_next;
   logic [NOTE_WIDTH-1:0]     note_reg;
   logic [DURATION_WIDTH-1:0] duration_reg;
   logic [DURATION_WIDTH-1:0] beats_left_reg, beats_left_next;
   logic [PHASE_WIDTH-1:0]    step_reg;
   logic [PHASE_WIDTH-1:0]    phase_reg, phase_next;
   logic                      note_done_reg, note_done_next;
   logic                      sample_valid_reg;
   logic                      is_rest_reg;
   logic [NOTE_WIDTH-1:0]     rom_addr;
   logic [PHASE_WIDTH-1:0]    rom_data;

   // Address the ROM with the incoming note on the strobe cycle so the step
   // is already valid during LOAD.
   assign rom_addr = new_note ? note : note_reg;

   frequency_rom #(
      .PHASE_WIDTH (PHASE_WIDTH)
   ) u_frequency_rom (
      .clk  (clk),
      .addr (rom_addr),
      .data (rom_data)
   );

   always_comb begin
      state_next      = state_reg;
      beats_left_next = beats_left_reg;
      if (new_note) begin
         state_next = LOAD;
      end else if (play) begin
         case (state_reg)
            IDLE: state_next = IDLE;
            LOAD: begin
               if (duration_reg == '0) begin
                  state_next = DONE;
               end else begin
                  state_next      = PLAYING;
                  beats_left_next = duration_reg;
               end
            end
            PLAYING: begin
               if (beat) begin
                  if (beats_left_reg == DURATION_WIDTH'(1)) begin
                     state_next      = DONE;
                     beats_left_next = '0;
                  end else begin
                     beats_left_next = beats_left_reg - DURATION_WIDTH'(1);
                  end
               end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Only the transition into DONE pulses, so a pause while in DONE cannot repeat it.
   assign note_done_next = (state_next == DONE) && (state_reg != DONE);

   always_comb begin
      phase_next = phase_reg;
      if (play) begin
         if (new_note)
            phase_next = '0;
         else if (generate_next_sample)
            phase_next = phase_reg + step_reg;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg        <= IDLE;
         note_reg         <= '0;
         duration_reg     <= '0;
         beats_left_reg   <= '0;
         step_reg         <= '0;
         phase_reg        <= '0;
         note_done_reg    <= 1'b0;
         sample_valid_reg <= 1'b0;
         is_rest_reg      <= 1'b1;
      end else begin
         state_reg        <= state_next;
         beats_left_reg   <= beats_left_next;
         phase_reg        <= phase_next;
         note_done_reg    <= note_done_next;
         sample_valid_reg <= play && generate_next_sample;
         if (state_reg == LOAD)
            step_reg <= rom_data;
         if (new_note) begin
            note_reg     <= note;
            duration_reg <= duration;
            is_rest_reg  <= (note == '0);
         end
      end
   end

   assign note_done    = note_done_reg;
   assign sample_valid = sample_valid_reg;
   assign is_rest      = is_rest_reg;
   assign sample_addr  = phase_reg[PHASE_WIDTH-1 -: ADDR_WIDTH];

endmodule

// File: tb/tb_note_player.sv
// Self-checking bench for note_player: directed table, corner-case sequences
// and random stimulus against a behavioural voice model.
module tb_note_player;
   import song_defs_pkg::*;

   localparam int PW = 22;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic          play;
   logic          new_note;
   logic [5:0]    note;
   logic [5:0]    duration;
   logic          beat;
   logic          generate_next_sample;
   logic          note_done;
   logic [AW-1:0] sample_addr;
   logic          sample_valid;
   logic          is_rest;

   note_player #(.PHASE_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
      .clk                  (clk),
      .reset                (reset),
      .play                 (play),
      .new_note             (new_note),
      .note                 (note),
      .duration             (duration),
      .beat                 (beat),
      .generate_next_sample (generate_next_sample),
      .note_done            (note_done),
      .sample_addr          (sample_addr),
      .sample_valid         (sample_valid),
      .is_rest              (is_rest)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   int unsigned base_step [12] = '{153791, 162936, 172624, 182889, 193764, 205286,
                                   217493, 230426, 244128, 258644, 274024, 290318};

   function automatic int unsigned ref_step(input int n);
      if (n == 0) return 0;
      return base_step[(n - 1) % 12] / (1 << (5 - (n - 1) / 12));
   endfunction

   // Behavioural voice model
   bit          m_loading, m_playing, m_rest, m_done, m_valid;
   int          m_left, m_note, m_dur;
   int unsigned m_step, m_phase;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_loading = 0; m_playing = 0; m_rest = 1; m_done = 0; m_valid = 0;
      m_left = 0; m_note = 0; m_dur = 0; m_step = 0; m_phase = 0;
   endtask

   task automatic model_step();
      m_done  = 0;
      m_valid = play && generate_next_sample;
      if (play && new_note)
         m_phase = 0;
      else if (play && generate_next_sample)
         m_phase = (m_phase + m_step) & 32'h003F_FFFF;
      if (m_loading)
         m_step = ref_step(m_note);
      if (new_note) begin
         m_rest = (note == 0);
         m_loading = 1; m_playing = 0;
         m_note = int'(note); m_dur = int'(duration);
      end else if (play) begin
         if (m_loading) begin
            m_loading = 0;
            if (m_dur == 0) m_done = 1;
            else begin m_playing = 1; m_left = m_dur; end
         end else if (m_playing && beat) begin
            m_left--;
            if (m_left == 0) begin m_playing = 0; m_done = 1; end
         end
      end
   endtask

   task automatic drive(input bit p, input bit nn, input int n, input int d,
                        input bit b, input bit g);
      play = p; new_note = nn; note = 6'(n); duration = 6'(d);
      beat = b; generate_next_sample = g;
   endtask

   // One clock: advance model with current inputs, then compare after the edge.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check("note_done", note_done, m_done);
      check("sample_valid", sample_valid, m_valid);
      check("is_rest", is_rest, m_rest);
      check("sample_addr", sample_addr, m_phase >> 12);
   endtask

   typedef struct {
      bit p, nn; int n, d; bit b, g;
      bit e_done, e_valid, e_rest; int e_addr;
   } vec_t;

   vec_t vecs [7];
   int   cnt_done, cnt_valid;

   initial begin
      vecs[0] = '{1, 1, 1, 3, 0, 0, 0, 0, 0, 0};
      vecs[1] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vecs[2] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
      vecs[3] = '{1, 0, 0, 0, 0, 1, 0, 1, 0, 1};
      vecs[4] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      vecs[5] = '{1, 0, 0, 0, 1, 0, 1, 0, 0, 1};
      vecs[6] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1};

      drive(0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      model_reset();
      #12;
      check("rst_note_done", note_done, 0);
      check("rst_sample_valid", sample_valid, 0);
      check("rst_sample_addr", sample_addr, 0);
      check("rst_is_rest", is_rest, 1);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Note 1, three beats: note_done one cycle after the third beat
      for (int i = 0; i < 7; i++) begin
         drive(vecs[i].p, vecs[i].nn, vecs[i].n, vecs[i].d, vecs[i].b, vecs[i].g);
         tick();
         check("vec_done", note_done, vecs[i].e_done);
         check("vec_valid", sample_valid, vecs[i].e_valid);
         check("vec_rest", is_rest, vecs[i].e_rest);
         check("vec_addr", sample_addr, vecs[i].e_addr);
         if (i == 1) check("vec_state_playing", int'(dut.state_reg), int'(PLAYING));
      end

      // Note 10, four sample requests
      drive(1, 1, 10, 2, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0);  tick();
      cnt_valid = 0;
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 0, 0, 1); tick();
         cnt_valid += int'(sample_valid);
      end
      check("n10_phase", dut.phase_reg, 32328);
      check("n10_addr", sample_addr, 7);
      check("n10_valid_pulses", cnt_valid, 4);
      drive(1, 0, 0, 0, 1, 0); tick();
      drive(1, 0, 0, 0, 1, 0); tick();
      check("n10_done", note_done, 1);

      // Rest, one beat
      drive(1, 1, 0, 1, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 1); tick();
      drive(1, 0, 0, 0, 0, 1); tick();
      check("rest_is_rest", is_rest, 1);
      check("rest_addr", sample_addr, 0);
      check("rest_valid", sample_valid, 1);
      drive(1, 0, 0, 0, 1, 0); tick();
      check("rest_done", note_done, 1);

      // Zero duration: done two cycles after new_note with no beat
      drive(1, 1, 3, 0, 0, 0); tick();
      check("dur0_not_yet", note_done, 0);
      drive(1, 0, 0, 0, 0, 0); tick();
      check("dur0_done", note_done, 1);
      drive(1, 0, 0, 0, 0, 0); tick();
      check("dur0_single", note_done, 0);

      // Pause mid-note
      cnt_done = 0;
      drive(1, 1, 5, 4, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 1, 0); tick();
      drive(1, 0, 0, 0, 1, 0); tick();
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 0, 0, i[0], 1); tick();
         cnt_done += int'(note_done);
         if (i > 0) check("pause_valid", sample_valid, 0);
      end
      drive(1, 0, 0, 0, 1, 0); tick();
      cnt_done += int'(note_done);
      check("pause_3rd_beat_no_done", note_done, 0);
      drive(1, 0, 0, 0, 1, 0); tick();
      cnt_done += int'(note_done);
      check("pause_4th_beat_done", note_done, 1);
      check("pause_done_count", cnt_done, 1);

      // Abort with simultaneous beat
      cnt_done = 0;
      drive(1, 1, 2, 4, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 1, 0); tick(); cnt_done += int'(note_done);
      drive(1, 1, 7, 1, 1, 0); tick(); cnt_done += int'(note_done);
      drive(1, 0, 0, 0, 1, 0); tick(); cnt_done += int'(note_done);
      drive(1, 0, 0, 0, 0, 0); tick(); cnt_done += int'(note_done);
      check("abort_no_done", cnt_done, 0);
      drive(1, 0, 0, 0, 1, 0); tick();
      check("abort_restart_done", note_done, 1);

      // Reset mid-note
      drive(1, 1, 9, 5, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0); tick();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 0, 0, 1); tick();
      end
      check("pre_rst_addr", sample_addr, 5);
      #2;
      reset = 1'b1;
      #1;
      check("midrst_note_done", note_done, 0);
      check("midrst_sample_valid", sample_valid, 0);
      check("midrst_sample_addr", sample_addr, 0);
      check("midrst_is_rest", is_rest, 1);
      model_reset();
      drive(1, 0, 0, 0, 1, 0);
      @(negedge clk);
      reset = 1'b0;
      tick();

      // Random traffic against the model
      for (int i = 0; i < 500; i++) begin
         drive($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
               int'($urandom_range(0, 63)), int'($urandom_range(0, 5)),
               $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
